date_diff_ctrl: RTL

- Sequencing controller that accepts a pair of packed dates and validates both.
- Time-multiplexes a single shared days_sum instance (with its is_leap_year/month_to_days) to convert date A, then date B, to absolute day counts.
- Returns the signed difference (B minus A) and the day-of-week of A, using an iterative mod-7 divider.
- Sits between the calendar UI/command front end and the days_sum datapath; only one converter is instantiated.

---
 rtl/date_diff_if.sv | 33 +++
 rtl/date_diff_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/date_diff_if.sv
// Request/response bundle between the calendar command front end and
// date_diff_ctrl.
//   in_valid/in_ready   : request handshake carrying date_a/date_b
//   date_a/date_b       : packed dates, year [22:9], month [8:5], day [4:0]
//   out_valid/out_ready : response handshake
//   diff                : signed days(B) - days(A), two's complement
//   dow_a               : day-of-week of A, 0=Sun .. 6=Sat
//   err/err_sel         : invalid input flag, 0 = date_a failed, 1 = only date_b
interface date_diff_if;
  localparam int unsigned DATE_W = 23;
  localparam int unsigned DIFF_W = 23;

  logic              in_valid;
  logic              in_ready;
  logic [DATE_W-1:0] date_a;
  logic [DATE_W-1:0] date_b;
  logic              out_valid;
  logic              out_ready;
  logic [DIFF_W-1:0] diff;
  logic [2:0]        dow_a;
  logic              err;
  logic              err_sel;

  modport master (
    output in_valid, date_a, date_b, out_ready,
    input  in_ready, out_valid, diff, dow_a, err, err_sel
  );

  modport slave (
    input  in_valid, date_a, date_b, out_ready,
    output in_ready, out_valid, diff, dow_a, err, err_sel
  );
endinterface

// File: rtl/date_diff_ctrl.sv
// Date difference controller: validates a pair of packed dates, converts A
// then B to absolute day counts through one shared days_sum converter, and
// returns days(B) - days(A) plus the day-of-week of A from a serial mod-7
// divider.
//   clk     : system clock, rising edge
//   rst     : asynchronous active-high reset
//   bus     : date_diff_if slave (request in, result out)
module date_diff_ctrl #(
  parameter int unsigned MAX_YEAR = 9999,
  parameter int unsigned DAYS_W   = 22
) (
  input  logic        clk,
  input  logic        rst,
  date_diff_if.slave  bus
);

  localparam int unsigned DATE_W = 23;
  localparam int unsigned DIFF_W = DAYS_W + 1;
  localparam int unsigned CNT_W  = $clog2(DAYS_W);

  typedef enum logic [2:0] {
    IDLE, CHECK, CONV_A, CONV_B, DIV, DONE
  } state_e;

  // Gregorian leap year rule.
  function automatic logic is_leap_year(input logic [13:0] y);
    return (y % 14'd4 == 14'd0) &&
           ((y % 14'd100 != 14'd0) || (y % 14'd400 == 14'd0));
  endfunction

  // Length of month m of year y; 0 for an out-of-range month.
  function automatic logic [4:0] month_len(input logic [13:0] y, input logic [3:0] m);
    case (m)
      4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: return 5'd31;
      4'd4, 4'd6, 4'd9, 4'd11:                    return 5'd30;
      4'd2:    return is_leap_year(y) ? 5'd29 : 5'd28;
      default: return 5'd0;
    endcase
  endfunction

  // Days in the year preceding the first of month m (non-leap year).
  function automatic logic [8:0] month_to_days(input logic [3:0] m);
    case (m)
      4'd2:    return 9'd31;
      4'd3:    return 9'd59;
      4'd4:    return 9'd90;
      4'd5:    return 9'd120;
      4'd6:    return 9'd151;
      4'd7:    return 9'd181;
      4'd8:    return 9'd212;
      4'd9:    return 9'd243;
      4'd10:   return 9'd273;
      4'd11:   return 9'd304;
      4'd12:   return 9'd334;
      default: return 9'd0;
    endcase
  endfunction

  // Absolute day number with 0001-01-01 = 1 (a Monday).
  function automatic logic [DAYS_W-1:0] days_sum(input logic [13:0] y,
                                                 input logic [3:0]  m,
                                                 input logic [4:0]  d);
    logic [DAYS_W-1:0] yp;
    logic [DAYS_W-1:0] acc;
    yp  = DAYS_W'(y) - DAYS_W'(1);
    acc = yp * DAYS_W'(365) + yp / DAYS_W'(4) - yp / DAYS_W'(100) + yp / DAYS_W'(400);
    acc = acc + DAYS_W'(month_to_days(m));
    if (is_leap_year(y) && (m > 4'd2)) acc = acc + DAYS_W'(1);
    acc = acc + DAYS_W'(d);
    return acc;
  endfunction

  function automatic logic date_ok(input logic [DATE_W-1:0] dt);
    logic [13:0] y;
    logic [3:0]  m;
    logic [4:0]  d;
    y = dt[22:9];
    m = dt[8:5];
    d = dt[4:0];
    return (y != 14'd0) && (32'(y) <= MAX_YEAR) &&
           (m != 4'd0) && (m <= 4'd12) &&
           (d != 5'd0) && (d <= month_len(y, m));
  endfunction

  state_e              state_q, state_d;
  logic [DATE_W-1:0]   date_a_q, date_a_d;
  logic [DATE_W-1:0]   date_b_q, date_b_d;
  logic [DAYS_W-1:0]   days_a_q, days_a_d;
  logic [DAYS_W-1:0]   dividend_q, dividend_d;
  logic [2:0]          rem_q, rem_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DIFF_W-1:0]   diff_q, diff_d;
  logic [2:0]          dow_q, dow_d;
  logic                err_q, err_d;
  logic                err_sel_q, err_sel_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;

  // Shared converter: select is B only in CONV_B, A otherwise.
  logic                sel_b_c;
  logic [DATE_W-1:0]   conv_in_c;
  logic [DAYS_W-1:0]   conv_days_c;
  assign sel_b_c     = (state_q == CONV_B);
  assign conv_in_c   = sel_b_c ? date_b_q : date_a_q;
  assign conv_days_c = days_sum(conv_in_c[22:9], conv_in_c[8:5], conv_in_c[4:0]);

  // One restoring step of the mod-7 divider.
  logic [3:0] rem_sh_c;
  logic [2:0] rem_nxt_c;
  assign rem_sh_c  = {rem_q, dividend_q[DAYS_W-1]};
  assign rem_nxt_c = (rem_sh_c >= 4'd7) ? 3'(rem_sh_c - 4'd7) : rem_sh_c[2:0];

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    date_a_d   = date_a_q;
    date_b_d   = date_b_q;
    days_a_d   = days_a_q;
    dividend_d = dividend_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    diff_d     = diff_q;
    dow_d      = dow_q;
    err_d      = err_q;
    err_sel_d  = err_sel_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          date_a_d = bus.date_a;
          date_b_d = bus.date_b;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        err_d     = 1'b0;
        err_sel_d = 1'b0;
        if (!date_ok(date_a_q)) begin
          err_d   = 1'b1;
          diff_d  = '0;
          dow_d   = '0;
          state_d = DONE;
        end else if (!date_ok(date_b_q)) begin
          err_d     = 1'b1;
          err_sel_d = 1'b1;
          diff_d    = '0;
          dow_d     = '0;
          state_d   = DONE;
        end else begin
          state_d = CONV_A;
        end
      end
      CONV_A: begin
        days_a_d = conv_days_c;
        state_d  = CONV_B;
      end
      CONV_B: begin
        diff_d     = {1'b0, conv_days_c} - {1'b0, days_a_q};
        rem_d      = '0;
        dividend_d = days_a_q;
        cnt_d      = CNT_W'(DAYS_W - 1);
        state_d    = DIV;
      end
      DIV: begin
        rem_d      = rem_nxt_c;
        dividend_d = dividend_q << 1;
        cnt_d      = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          dow_d   = rem_nxt_c;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      date_a_q    <= '0;
      date_b_q    <= '0;
      days_a_q    <= '0;
      dividend_q  <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      diff_q      <= '0;
      dow_q       <= '0;
      err_q       <= 1'b0;
      err_sel_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      date_a_q    <= date_a_d;
      date_b_q    <= date_b_d;
      days_a_q    <= days_a_d;
      dividend_q  <= dividend_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      diff_q      <= diff_d;
      dow_q       <= dow_d;
      err_q       <= err_d;
      err_sel_q   <= err_sel_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.dow_a     = dow_q;
  assign bus.err       = err_q;
  assign bus.err_sel   = err_sel_q;

endmodule
